tlb_ctrl: RTL and testbench
===========================

TLB_CTRL -- requirements
Module: tlb_ctrl

Interface
REQ-001 SHALL have parameter ENTRIES, default 8, number of TLB entries (power of 2).
REQ-002 SHALL have parameter IDX_W, default 3, equal to log2(ENTRIES).
REQ-003 SHALL have port clk, input, 1, rising-edge clock; the block's only clock.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port cmd_valid, input, 1, CP0 TLB command request.
REQ-006 SHALL have port cmd_op, input, 2, command: 00 TLBR, 01 TLBWI, 10 TLBWR, 11 TLBP.
REQ-007 SHALL have port cmd_ready, output, 1, block idle and able to accept a command.
REQ-008 SHALL have port index_in, input, IDX_W, CP0 Index value.
REQ-009 SHALL have port entryhi_in, input, 32, CP0 EntryHi: VPN [31:12], ASID [7:0].
REQ-010 SHALL have port entrylo_in, input, 32, CP0 EntryLo: PFN [25:6], D/V/G [2:0].
REQ-011 SHALL have port done, output, 1, one-cycle command completion pulse.
REQ-012 SHALL have port rd_pfn, output, 20, PFN from the last TLBR; drives the EntryLo pfn input.
REQ-013 SHALL have port rd_dvg, output, 3, D/V/G from the last TLBR; drives the EntryLo dvg input.
REQ-014 SHALL have port rd_entryhi, output, 32, {VPN, 4'b0, ASID} from the last TLBR.
REQ-015 SHALL have port rd_we, output, 1, EntryHi write strobe for TLBR results.
REQ-016 SHALL have port probe_index, output, 32, TLBP result: bit31 P (1 = miss), [IDX_W-1:0] matching index.
REQ-017 SHALL have port probe_we, output, 1, Index write strobe for TLBP results.
REQ-018 SHALL have port random, output, IDX_W, CP0 Random value.
REQ-019 SHALL have ports lk_vaddr (input, 32) and lk_asid (input, 8), the translation request.
REQ-020 SHALL have ports lk_hit (output, 1), lk_dirty (output, 1) and lk_paddr (output, 32), the registered translation result.

Function
REQ-021 SHALL store per entry: valid flag, VPN[19:0], ASID[7:0], G, PFN[19:0], D, V.
REQ-022 SHALL match an entry when: the valid flag is 1, VPN equals the request VPN, and (G=1 or ASID equals the request ASID).
REQ-023 SHALL implement FSM states IDLE, PROBE and RESP; cmd_ready SHALL be 1 only in IDLE.
REQ-024 SHALL accept a command on a rising edge with cmd_valid=1 and cmd_ready=1; all inputs are sampled at that edge.
REQ-025 TLBWI SHALL write entry[index_in] at the acceptance edge, setting the valid flag to 1; the FSM then moves to RESP.
REQ-026 TLBWR SHALL behave as TLBWI, using the random value at the acceptance edge as the index.
REQ-027 TLBR SHALL register entry[index_in] into rd_pfn, rd_dvg and rd_entryhi at the acceptance edge; the FSM then moves to RESP.
REQ-028 TLBR of an invalid entry SHALL return that entry's stored fields unchanged (all zero after reset).
REQ-029 rd_pfn, rd_dvg and rd_entryhi SHALL hold their value until the next TLBR, because the EntryLo register samples them every cycle.
REQ-030 TLBP SHALL enter PROBE with pointer 0 and compare entry[pointer] against entryhi_in each cycle, one entry per cycle.
REQ-031 On the first match at index k, TLBP SHALL register probe_index = {1'b0, 0..., k} and move to RESP.
REQ-032 After entry ENTRIES-1 is compared without a match, TLBP SHALL register probe_index = 32'h8000_0000 and move to RESP.
REQ-033 In RESP, done=1 for exactly one cycle; rd_we=1 for TLBR and probe_we=1 for TLBP; the FSM then returns to IDLE.
REQ-034 Command latency SHALL be:
- TLBR, TLBWI, TLBWR: done in cycle 1 after acceptance.
- TLBP hit at entry k: done in cycle k+2.
- TLBP miss: done in cycle ENTRIES+1.
REQ-035 random SHALL decrement every cycle, wrapping from 0 to ENTRIES-1, independent of commands.
REQ-036 The lookup result SHALL be registered with one-cycle latency:
- lk_hit = 1 only if a matching entry also has V=1.
- lk_paddr = {PFN, lk_vaddr[11:0]}; lk_dirty = D.
REQ-037 On lookup multi-match, the lowest-index entry SHALL win.
REQ-038 On a miss, lk_paddr and lk_dirty SHALL be 0.
REQ-039 A lookup on the same edge as a TLB write SHALL see the pre-write contents.
REQ-040 cmd_valid while busy SHALL be ignored; no queuing.

Reset
REQ-041 rst_n=0 SHALL immediately force:
- FSM to IDLE and cmd_ready=1.
- All valid flags and stored entry fields to 0.
- random to ENTRIES-1.
- done, rd_we, probe_we, lk_hit, lk_dirty to 0.
- rd_pfn, rd_dvg, rd_entryhi, probe_index, lk_paddr to 0.
REQ-042 Reset asserted mid-TLBP SHALL abort the probe with no done pulse and no probe_we.

Verification
REQ-043 Reset release: 4 cycles later random=3 (7,6,5,4,3); cmd_ready=1; all outputs 0.
REQ-044 TLBWI index 2 (entryhi 0x00400005, entrylo 0x00001046), then TLBR index 2 -> rd_pfn=0x00041, rd_dvg=6, rd_entryhi=0x00400005, rd_we pulse in cycle 1.
REQ-045 After REQ-044, TLBP entryhi 0x00400005 -> probe_index=0x00000002, done in cycle 4; TLBP entryhi 0x00800005 -> probe_index=0x80000000, done in cycle 9.
REQ-046 Lookup vaddr 0x00400ABC, asid 5 -> next cycle lk_hit=1, lk_paddr=0x00041ABC, lk_dirty=1; with asid 6 and G=0 -> lk_hit=0.
REQ-047 rst_n low 3 cycles into a TLBP -> no done pulse; cmd_ready=1; a subsequent TLBR of index 2 returns all zeros.

Source files
------------

// File: rtl/tlb_ctrl.sv
// tlb_ctrl: CP0-side TLB controller for a small fully associative TLB.
// Executes TLBR / TLBWI / TLBWR / TLBP commands from CP0, maintains the
// Random register, and provides a registered one-cycle address translation.
//
// Command handshake: a command is taken on a rising edge where
// cmd_valid=1 and cmd_ready=1. cmd_ready is high only while the FSM is
// IDLE. All command inputs are sampled on that edge only. A cmd_valid seen
// while busy is dropped, not queued. Every accepted command ends with a
// one-cycle done pulse.
module tlb_ctrl #(
  parameter int ENTRIES = 8,
  parameter int IDX_W   = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  input  logic [1:0]       cmd_op,
  output logic             cmd_ready,
  input  logic [IDX_W-1:0] index_in,
  input  logic [31:0]      entryhi_in,
  input  logic [31:0]      entrylo_in,
  output logic             done,
  output logic [19:0]      rd_pfn,
  output logic [2:0]       rd_dvg,
  output logic [31:0]      rd_entryhi,
  output logic             rd_we,
  output logic [31:0]      probe_index,
  output logic             probe_we,
  output logic [IDX_W-1:0] random,
  input  logic [31:0]      lk_vaddr,
  input  logic [7:0]       lk_asid,
  output logic             lk_hit,
  output logic             lk_dirty,
  output logic [31:0]      lk_paddr,
  output logic [1:0]       dbg_state
);

  localparam logic [1:0] OP_TLBR  = 2'b00;
  localparam logic [1:0] OP_TLBWI = 2'b01;
  localparam logic [1:0] OP_TLBWR = 2'b10;
  localparam logic [1:0] OP_TLBP  = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PROBE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t state;

  // Entry storage, one element per TLB slot.
  logic [ENTRIES-1:0] ent_valid;
  logic [ENTRIES-1:0] ent_g;
  logic [ENTRIES-1:0] ent_d;
  logic [ENTRIES-1:0] ent_v;
  logic [19:0]        ent_vpn  [ENTRIES];
  logic [7:0]         ent_asid [ENTRIES];
  logic [19:0]        ent_pfn  [ENTRIES];

  // Probe context captured when TLBP is accepted.
  logic [IDX_W-1:0] probe_ptr;
  logic [19:0]      probe_vpn;
  logic [7:0]       probe_asid;
  logic             probe_match;

  // Lookup search result.
  logic             lk_found;
  logic [IDX_W-1:0] lk_sel;

  logic             accept;
  logic             wr_en;
  logic [IDX_W-1:0] wr_idx;

  // Fields of EntryHi/EntryLo that the TLB does not store.
  logic unused_bits;
  assign unused_bits = ^{entryhi_in[11:8], entrylo_in[31:26], entrylo_in[5:3]};

  assign cmd_ready = (state == IDLE);
  assign dbg_state = state;
  assign accept    = cmd_valid && cmd_ready;
  assign wr_en     = accept && ((cmd_op == OP_TLBWI) || (cmd_op == OP_TLBWR));
  assign wr_idx    = (cmd_op == OP_TLBWR) ? random : index_in;

  assign probe_match = ent_valid[probe_ptr] &&
                       (ent_vpn[probe_ptr] == probe_vpn) &&
                       (ent_g[probe_ptr] || (ent_asid[probe_ptr] == probe_asid));

  // Random counts down every cycle and wraps naturally (ENTRIES is a power of 2).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      random <= IDX_W'(ENTRIES - 1);
    end else begin
      random <= random - IDX_W'(1);
    end
  end

  // Entry array: written by TLBWI/TLBWR on the acceptance edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent_valid <= '0;
      ent_g     <= '0;
      ent_d     <= '0;
      ent_v     <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        ent_vpn[i]  <= '0;
        ent_asid[i] <= '0;
        ent_pfn[i]  <= '0;
      end
    end else if (wr_en) begin
      ent_valid[wr_idx] <= 1'b1;
      ent_vpn[wr_idx]   <= entryhi_in[31:12];
      ent_asid[wr_idx]  <= entryhi_in[7:0];
      ent_pfn[wr_idx]   <= entrylo_in[25:6];
      ent_d[wr_idx]     <= entrylo_in[2];
      ent_v[wr_idx]     <= entrylo_in[1];
      ent_g[wr_idx]     <= entrylo_in[0];
    end
  end

  // Command FSM with registered response outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      probe_ptr   <= '0;
      probe_vpn   <= '0;
      probe_asid  <= '0;
      done        <= 1'b0;
      rd_we       <= 1'b0;
      probe_we    <= 1'b0;
      rd_pfn      <= '0;
      rd_dvg      <= '0;
      rd_entryhi  <= '0;
      probe_index <= '0;
    end else begin
      done     <= 1'b0;
      rd_we    <= 1'b0;
      probe_we <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            case (cmd_op)
              OP_TLBR: begin
                rd_pfn     <= ent_pfn[index_in];
                rd_dvg     <= {ent_d[index_in], ent_v[index_in], ent_g[index_in]};
                rd_entryhi <= {ent_vpn[index_in], 4'b0000, ent_asid[index_in]};
                rd_we      <= 1'b1;
                done       <= 1'b1;
                state      <= RESP;
              end
              OP_TLBWI, OP_TLBWR: begin
                done  <= 1'b1;
                state <= RESP;
              end
              default: begin
                probe_ptr  <= '0;
                probe_vpn  <= entryhi_in[31:12];
                probe_asid <= entryhi_in[7:0];
                state      <= PROBE;
              end
            endcase
          end
        end
        PROBE: begin
          if (probe_match) begin
            probe_index <= 32'(probe_ptr);
            probe_we    <= 1'b1;
            done        <= 1'b1;
            state       <= RESP;
          end else if (probe_ptr == IDX_W'(ENTRIES - 1)) begin
            probe_index <= 32'h8000_0000;
            probe_we    <= 1'b1;
            done        <= 1'b1;
            state       <= RESP;
          end else begin
            probe_ptr <= probe_ptr + IDX_W'(1);
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Lookup search: descending scan so the lowest matching index wins.
  always_comb begin
    lk_found = 1'b0;
    lk_sel   = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (ent_valid[i] && (ent_vpn[i] == lk_vaddr[31:12]) &&
          (ent_g[i] || (ent_asid[i] == lk_asid))) begin
        lk_found = 1'b1;
        lk_sel   = IDX_W'(i);
      end
    end
  end

  // Registered translation result; a matching entry with V=0 is a miss.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lk_hit   <= 1'b0;
      lk_dirty <= 1'b0;
      lk_paddr <= '0;
    end else if (lk_found && ent_v[lk_sel]) begin
      lk_hit   <= 1'b1;
      lk_dirty <= ent_d[lk_sel];
      lk_paddr <= {ent_pfn[lk_sel], lk_vaddr[11:0]};
    end else begin
      lk_hit   <= 1'b0;
      lk_dirty <= 1'b0;
      lk_paddr <= '0;
    end
  end

endmodule

// File: tb/tb_tlb_ctrl.sv
// tb_tlb_ctrl: directed, table-driven bench for tlb_ctrl.
module tb_tlb_ctrl;

  localparam logic [1:0] OP_R  = 2'b00;
  localparam logic [1:0] OP_WI = 2'b01;
  localparam logic [1:0] OP_WR = 2'b10;
  localparam logic [1:0] OP_P  = 2'b11;

  logic        clk;
  logic        rst_n;
  logic        cmd_valid;
  logic [1:0]  cmd_op;
  logic        cmd_ready;
  logic [2:0]  index_in;
  logic [31:0] entryhi_in;
  logic [31:0] entrylo_in;
  logic        done;
  logic [19:0] rd_pfn;
  logic [2:0]  rd_dvg;
  logic [31:0] rd_entryhi;
  logic        rd_we;
  logic [31:0] probe_index;
  logic        probe_we;
  logic [2:0]  random;
  logic [31:0] lk_vaddr;
  logic [7:0]  lk_asid;
  logic        lk_hit;
  logic        lk_dirty;
  logic [31:0] lk_paddr;
  logic [1:0]  dbg_state;

  typedef struct {
    logic [1:0]  op;
    logic [2:0]  idx;
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
    logic [19:0] pfn;
    logic [2:0]  dvg;
    logic [31:0] ehi;
    logic [31:0] pidx;
  } vec_t;

  vec_t vt [13];

  int n_pass;
  int n_total;

  // Expected held values of the TLBR / TLBP result registers.
  logic [19:0] exp_pfn;
  logic [2:0]  exp_dvg;
  logic [31:0] exp_ehi;
  logic [31:0] exp_pidx;

  // Reference model of the Random register.
  logic [2:0] rnd_model;

  tlb_ctrl #(.ENTRIES(8), .IDX_W(3)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cmd_valid   (cmd_valid),
    .cmd_op      (cmd_op),
    .cmd_ready   (cmd_ready),
    .index_in    (index_in),
    .entryhi_in  (entryhi_in),
    .entrylo_in  (entrylo_in),
    .done        (done),
    .rd_pfn      (rd_pfn),
    .rd_dvg      (rd_dvg),
    .rd_entryhi  (rd_entryhi),
    .rd_we       (rd_we),
    .probe_index (probe_index),
    .probe_we    (probe_we),
    .random      (random),
    .lk_vaddr    (lk_vaddr),
    .lk_asid     (lk_asid),
    .lk_hit      (lk_hit),
    .lk_dirty    (lk_dirty),
    .lk_paddr    (lk_paddr),
    .dbg_state   (dbg_state)
  );

  // Clock and reset-aware random model.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) rnd_model <= 3'd7;
    else        rnd_model <= rnd_model - 3'd1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", nm, act, exp);
  endtask

  task automatic chk_idle_zero(input string tag, input logic [2:0] exp_rnd);
    chk({tag, "_ready"},  32'(cmd_ready),   32'd1);
    chk({tag, "_done"},   32'(done),        32'd0);
    chk({tag, "_rdwe"},   32'(rd_we),       32'd0);
    chk({tag, "_pwe"},    32'(probe_we),    32'd0);
    chk({tag, "_lkhit"},  32'(lk_hit),      32'd0);
    chk({tag, "_lkd"},    32'(lk_dirty),    32'd0);
    chk({tag, "_pfn"},    32'(rd_pfn),      32'd0);
    chk({tag, "_dvg"},    32'(rd_dvg),      32'd0);
    chk({tag, "_ehi"},    rd_entryhi,       32'd0);
    chk({tag, "_pidx"},   probe_index,      32'd0);
    chk({tag, "_paddr"},  lk_paddr,         32'd0);
    chk({tag, "_random"}, 32'(random),      32'(exp_rnd));
  endtask

  // Driver: issue one command at a negedge, wait (bounded) for done, check results.
  task automatic run_cmd(input string tag, input logic [1:0] op, input logic [2:0] idx,
                         input logic [31:0] hi, input logic [31:0] lo, input int exp_lat);
    int lat;
    bit got;
    cmd_valid  = 1'b1;
    cmd_op     = op;
    index_in   = idx;
    entryhi_in = hi;
    entrylo_in = lo;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    lat = 0;
    got = 1'b0;
    for (int c = 1; c <= 20 && !got; c++) begin
      @(negedge clk);
      if (c == 1) chk({tag, "_busy"}, 32'(cmd_ready), 32'd0);
      if (done) begin
        got = 1'b1;
        lat = c;
      end
    end
    chk({tag, "_lat"},   32'(lat),      32'(exp_lat));
    chk({tag, "_rdwe"},  32'(rd_we),    32'(op == OP_R));
    chk({tag, "_pwe"},   32'(probe_we), 32'(op == OP_P));
    chk({tag, "_pfn"},   32'(rd_pfn),   32'(exp_pfn));
    chk({tag, "_dvg"},   32'(rd_dvg),   32'(exp_dvg));
    chk({tag, "_ehi"},   rd_entryhi,    exp_ehi);
    chk({tag, "_pidx"},  probe_index,   exp_pidx);
    @(negedge clk);
    chk({tag, "_done1"}, 32'(done),      32'd0);
    chk({tag, "_idle"},  32'(cmd_ready), 32'd1);
  endtask

  task automatic apply_vec(input int n, input vec_t v);
    if (v.op == OP_R) begin
      exp_pfn = v.pfn;
      exp_dvg = v.dvg;
      exp_ehi = v.ehi;
    end
    if (v.op == OP_P) exp_pidx = v.pidx;
    run_cmd($sformatf("v%0d", n), v.op, v.idx, v.hi, v.lo, v.lat);
  endtask

  task automatic lookup(input string tag, input logic [31:0] va, input logic [7:0] asid,
                        input logic e_hit, input logic [31:0] e_pa, input logic e_d);
    lk_vaddr = va;
    lk_asid  = asid;
    @(negedge clk);
    chk({tag, "_hit"},   32'(lk_hit),   32'(e_hit));
    chk({tag, "_paddr"}, lk_paddr,      e_pa);
    chk({tag, "_dirty"}, 32'(lk_dirty), 32'(e_d));
  endtask

  initial begin
    int    lat;
    bit    got;
    int    n_done;
    logic [2:0] wr_i;

    //          op     idx   entryhi       entrylo       lat pfn       dvg   entryhi_rd    probe_index
    vt[0]  = '{OP_WI, 3'd2, 32'h00400005, 32'h00001046, 1, 20'h0,     3'd0, 32'h0,        32'h0};
    vt[1]  = '{OP_R,  3'd2, 32'h0,        32'h0,        1, 20'h00041, 3'd6, 32'h00400005, 32'h0};
    vt[2]  = '{OP_P,  3'd0, 32'h00400005, 32'h0,        4, 20'h0,     3'd0, 32'h0,        32'h00000002};
    vt[3]  = '{OP_P,  3'd0, 32'h00800005, 32'h0,        9, 20'h0,     3'd0, 32'h0,        32'h80000000};
    vt[4]  = '{OP_WI, 3'd5, 32'h12345F77, 32'h02AF3783, 1, 20'h0,     3'd0, 32'h0,        32'h0};
    vt[5]  = '{OP_P,  3'd0, 32'h12345A99, 32'h0,        7, 20'h0,     3'd0, 32'h0,        32'h00000005};
    vt[6]  = '{OP_R,  3'd5, 32'h0,        32'h0,        1, 20'hABCDE, 3'd3, 32'h12345077, 32'h0};
    vt[7]  = '{OP_R,  3'd0, 32'h0,        32'h0,        1, 20'h0,     3'd0, 32'h0,        32'h0};
    vt[8]  = '{OP_WI, 3'd0, 32'h00400005, 32'h00002006, 1, 20'h0,     3'd0, 32'h0,        32'h0};
    vt[9]  = '{OP_P,  3'd0, 32'h00400005, 32'h0,        2, 20'h0,     3'd0, 32'h0,        32'h00000000};
    vt[10] = '{OP_WI, 3'd7, 32'h7FFFF011, 32'h000048C2, 1, 20'h0,     3'd0, 32'h0,        32'h0};
    vt[11] = '{OP_P,  3'd0, 32'h7FFFF011, 32'h0,        9, 20'h0,     3'd0, 32'h0,        32'h00000007};
    vt[12] = '{OP_P,  3'd0, 32'h7FFFF012, 32'h0,        9, 20'h0,     3'd0, 32'h0,        32'h80000000};

    n_pass     = 0;
    n_total    = 0;
    exp_pfn    = '0;
    exp_dvg    = '0;
    exp_ehi    = '0;
    exp_pidx   = '0;
    rst_n      = 1'b0;
    cmd_valid  = 1'b0;
    cmd_op     = 2'b00;
    index_in   = '0;
    entryhi_in = '0;
    entrylo_in = '0;
    lk_vaddr   = '0;
    lk_asid    = '0;

    // Reset state and Random sequence after release.
    repeat (2) @(negedge clk);
    chk_idle_zero("rst", 3'd7);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk_idle_zero("rel4", 3'd3);

    // Write / read / probe vectors, part 1.
    for (int i = 0; i < 8; i++) apply_vec(i, vt[i]);

    lookup("lk_a5",  32'h00400ABC, 8'h05, 1'b1, 32'h00041ABC, 1'b1);
    lookup("lk_a6",  32'h00400ABC, 8'h06, 1'b0, 32'h00000000, 1'b0);
    lookup("lk_glb", 32'h12345123, 8'h42, 1'b1, 32'hABCDE123, 1'b0);

    // Part 2: duplicate VPN at a lower index, boundary probes.
    for (int i = 8; i < 13; i++) apply_vec(i, vt[i]);

    lookup("lk_low", 32'h00400FFF, 8'h05, 1'b1, 32'h00080FFF, 1'b1);
    lookup("lk_e7",  32'h7FFFF000, 8'h11, 1'b1, 32'h00123000, 1'b0);

    // Lookup on the same edge as a write sees the old contents.
    lk_vaddr   = 32'h55555000;
    lk_asid    = 8'h01;
    cmd_valid  = 1'b1;
    cmd_op     = OP_WI;
    index_in   = 3'd3;
    entryhi_in = 32'h55555001;
    entrylo_in = 32'h0001DDC2;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(negedge clk);
    chk("same_edge_done",  32'(done),   32'd1);
    chk("same_edge_lkhit", 32'(lk_hit), 32'd0);
    @(negedge clk);
    chk("after_wr_lkhit",  32'(lk_hit), 32'd1);
    chk("after_wr_paddr",  lk_paddr,    32'h00777000);

    // cmd_valid held during a probe must be ignored.
    cmd_valid  = 1'b1;
    cmd_op     = OP_P;
    index_in   = 3'd0;
    entryhi_in = 32'h0F0F0000;
    @(posedge clk);
    #1;
    cmd_op     = OP_WI;
    index_in   = 3'd6;
    entrylo_in = 32'h00000002;
    lat = 0;
    got = 1'b0;
    for (int c = 1; c <= 20 && !got; c++) begin
      @(negedge clk);
      if (done) begin
        got = 1'b1;
        lat = c;
        cmd_valid = 1'b0;
      end
    end
    cmd_valid = 1'b0;
    exp_pidx  = 32'h80000000;
    chk("busy_lat",  32'(lat),   32'd9);
    chk("busy_pidx", probe_index, exp_pidx);
    @(negedge clk);
    chk("busy_done1", 32'(done), 32'd0);
    exp_pfn = '0;
    exp_dvg = '0;
    exp_ehi = '0;
    run_cmd("busy_rd6", OP_R, 3'd6, 32'h0, 32'h0, 1);

    // TLBWR lands at the Random value seen on the acceptance edge.
    wr_i = rnd_model;
    chk("rnd_model", 32'(random), 32'(rnd_model));
    run_cmd("wr", OP_WR, 3'd0, 32'h0ABCD0EE, 32'h0003C3C3, 1);
    exp_pfn = 20'h00F0F;
    exp_dvg = 3'd3;
    exp_ehi = 32'h0ABCD0EE;
    run_cmd("wr_rd", OP_R, wr_i, 32'h0, 32'h0, 1);

    // Reset three cycles into a probe: no done, everything cleared.
    cmd_valid  = 1'b1;
    cmd_op     = OP_P;
    entryhi_in = 32'h0BAD0000;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    n_done = 0;
    repeat (3) begin
      @(negedge clk);
      if (done) n_done++;
    end
    rst_n = 1'b0;
    #1;
    chk_idle_zero("midrst", 3'd7);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (done || probe_we) n_done++;
      if (c == 3) chk("midrst_rnd", 32'(random), 32'd3);
    end
    chk("midrst_nodone", 32'(n_done), 32'd0);
    exp_pfn  = '0;
    exp_dvg  = '0;
    exp_ehi  = '0;
    exp_pidx = '0;
    run_cmd("midrst_rd2", OP_R, 3'd2, 32'h0, 32'h0, 1);
    exp_pidx = 32'h80000000;
    run_cmd("midrst_p", OP_P, 3'd0, 32'h00400005, 32'h0, 9);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
